// File: rtl/noc_pkg.sv
// Shared FSM state type, request-entry struct and default sizes for the NoC memory arbiter.
package noc_pkg;

  localparam int unsigned DefBitWidth      = 512;
  localparam int unsigned DefRadix         = 2;
  localparam int unsigned DefAddrWidth     = 32;
  localparam int unsigned DefFifoDepth     = 4;
  localparam int unsigned DefTimeoutCycles = 256;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } arb_state_e;

  typedef struct packed {
    logic [DefAddrWidth-1:0] addr;
    logic [DefBitWidth-1:0]  data;
    logic                    we;
  } req_entry_t;

endpackage

// File: rtl/noc_req_fifo.sv
// Per-core request queue: power-of-two deep FIFO of request entries with first-word head output.
module noc_req_fifo
  import noc_pkg::*;
#(
  parameter int unsigned Depth   = DefFifoDepth,
  parameter type         entry_t = req_entry_t
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   push_i,
  input  entry_t entry_i,
  input  logic   pop_i,
  output entry_t head_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   cnt_q, cnt_d;
  logic            do_push, do_pop;

  entry_t mem_q [Depth];

  assign full_o  = (cnt_q == (PtrW + 1)'(Depth));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    // Simultaneous push and pop leaves occupancy unchanged.
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (PtrW + 1)'(1);
      2'b01:   cnt_d = cnt_q - (PtrW + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read when the count says they are valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= entry_i;
  end

endmodule

// File: rtl/noc_mem_arbiter.sv
// Round-robin arbiter giving RADIX cores single-outstanding access to one memory port.
// Optional WAIT-state timeout is enabled by defining NOC_ARB_TIMEOUT_EN.
module noc_mem_arbiter
  import noc_pkg::*;
#(
  parameter int unsigned BIT_WIDTH      = DefBitWidth,
  parameter int unsigned RADIX          = DefRadix,
  parameter int unsigned ADDR_WIDTH     = DefAddrWidth,
  parameter int unsigned FIFO_DEPTH     = DefFifoDepth,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
  input  logic                             clock,
  input  logic                             rst_l,
  input  logic [RADIX-1:0]                 Valid_C2M,
  output logic [RADIX-1:0]                 Ready_C2M,
  input  logic [RADIX-1:0][BIT_WIDTH-1:0]  Data_C2M,
  input  logic [RADIX-1:0][ADDR_WIDTH-1:0] Addr_C2M,
  input  logic [RADIX-1:0]                 We_C2M,
  output logic                             ReqValid_A2M,
  input  logic                             ReqReady_A2M,
  output logic [ADDR_WIDTH-1:0]            Addr_A2M,
  output logic [BIT_WIDTH-1:0]             Data_A2M,
  output logic                             We_A2M,
  input  logic                             CompleteValid_M2A,
  input  logic [ADDR_WIDTH-1:0]            AccessComplete_M2C,
  input  logic [BIT_WIDTH-1:0]             Data_M2C,
  output logic [RADIX-1:0]                 RespValid_A2C,
  output logic [BIT_WIDTH-1:0]             RespData_A2C,
  output logic                             Timeout_err
);

  localparam int unsigned GntW = (RADIX > 1) ? $clog2(RADIX) : 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [BIT_WIDTH-1:0]  data;
    logic                  we;
  } entry_t;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || RADIX == 0 ||
      TIMEOUT_CYCLES == 0) begin : g_bad_param
    $error("noc_mem_arbiter: illegal parameterisation");
  end

  arb_state_e           state_q, state_d;
  logic [GntW-1:0]      gnt_q, gnt_d;
  logic [GntW-1:0]      winner;
  entry_t               entry_q, entry_d;
  logic [BIT_WIDTH-1:0] rdata_q, rdata_d;
  logic [RADIX-1:0]     pop, full, empty;
  entry_t               heads [RADIX];
  logic                 addr_match;
  logic                 expired;
  int unsigned          rr_idx;
  logic                 rr_found;

  for (genvar i = 0; i < RADIX; i++) begin : g_fifo
    entry_t push_entry;
    assign push_entry = '{addr: Addr_C2M[i], data: Data_C2M[i], we: We_C2M[i]};

    noc_req_fifo #(
      .Depth  (FIFO_DEPTH),
      .entry_t(entry_t)
    ) u_fifo (
      .clk_i  (clock),
      .rst_ni (rst_l),
      .push_i (Valid_C2M[i] & Ready_C2M[i]),
      .entry_i(push_entry),
      .pop_i  (pop[i]),
      .head_o (heads[i]),
      .full_o (full[i]),
      .empty_o(empty[i])
    );
  end

  assign Ready_C2M = ~full;

  // Round-robin search starting one past the last grant.
  always_comb begin
    winner   = gnt_q;
    rr_found = 1'b0;
    rr_idx   = 0;
    for (int unsigned i = 1; i <= RADIX; i++) begin
      rr_idx = (32'(gnt_q) + i) % RADIX;
      if (!rr_found && !empty[GntW'(rr_idx)]) begin
        winner   = GntW'(rr_idx);
        rr_found = 1'b1;
      end
    end
  end

  assign addr_match = CompleteValid_M2A && (AccessComplete_M2C == entry_q.addr);

`ifdef NOC_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;

  assign expired = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d     = '0;
    timeout_d = timeout_q;
    if (state_q == StWait) begin
      cnt_d = cnt_q + CntW'(1);
      if (expired && !addr_match) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign Timeout_err = timeout_q;
`else
  assign expired     = 1'b0;
  assign Timeout_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    entry_d = entry_q;
    rdata_d = rdata_q;
    pop     = '0;
    unique case (state_q)
      StIdle: begin
        if (rr_found) begin
          gnt_d       = winner;
          entry_d     = heads[winner];
          pop[winner] = 1'b1;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        if (ReqReady_A2M) state_d = StWait;
      end
      StWait: begin
        if (addr_match) begin
          rdata_d = Data_M2C;
          state_d = StResp;
        end else if (expired) begin
          // A timed-out access is answered with zero data so the core is not left hanging.
          rdata_d = '0;
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= StIdle;
      gnt_q   <= GntW'(RADIX - 1);
      entry_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      entry_q <= entry_d;
      rdata_q <= rdata_d;
    end
  end

  assign ReqValid_A2M = (state_q == StIssue);
  assign Addr_A2M     = entry_q.addr;
  assign Data_A2M     = entry_q.data;
  assign We_A2M       = entry_q.we;
  assign RespData_A2C = (state_q == StResp) ? rdata_q : '0;

  always_comb begin
    RespValid_A2C = '0;
    if (state_q == StResp) RespValid_A2C[gnt_q] = 1'b1;
  end

endmodule

// File: tb/tb_noc_mem_arbiter.sv
// Directed self-checking bench for noc_mem_arbiter (2 ports, 32-bit data/address, depth 4).
module tb_noc_mem_arbiter;

  localparam int BW = 32;
  localparam int AW = 32;

  logic                clock;
  logic                rst_l;
  logic [1:0]          Valid_C2M;
  logic [1:0]          Ready_C2M;
  logic [1:0][BW-1:0]  Data_C2M;
  logic [1:0][AW-1:0]  Addr_C2M;
  logic [1:0]          We_C2M;
  logic                ReqValid_A2M;
  logic                ReqReady_A2M;
  logic [AW-1:0]       Addr_A2M;
  logic [BW-1:0]       Data_A2M;
  logic                We_A2M;
  logic                CompleteValid_M2A;
  logic [AW-1:0]       AccessComplete_M2C;
  logic [BW-1:0]       Data_M2C;
  logic [1:0]          RespValid_A2C;
  logic [BW-1:0]       RespData_A2C;
  logic                Timeout_err;

  int total = 0;
  int bad   = 0;

  noc_mem_arbiter #(
    .BIT_WIDTH     (BW),
    .RADIX         (2),
    .ADDR_WIDTH    (AW),
    .FIFO_DEPTH    (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clock             (clock),
    .rst_l             (rst_l),
    .Valid_C2M         (Valid_C2M),
    .Ready_C2M         (Ready_C2M),
    .Data_C2M          (Data_C2M),
    .Addr_C2M          (Addr_C2M),
    .We_C2M            (We_C2M),
    .ReqValid_A2M      (ReqValid_A2M),
    .ReqReady_A2M      (ReqReady_A2M),
    .Addr_A2M          (Addr_A2M),
    .Data_A2M          (Data_A2M),
    .We_A2M            (We_A2M),
    .CompleteValid_M2A (CompleteValid_M2A),
    .AccessComplete_M2C(AccessComplete_M2C),
    .Data_M2C          (Data_M2C),
    .RespValid_A2C     (RespValid_A2C),
    .RespData_A2C      (RespData_A2C),
    .Timeout_err       (Timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic zero_inputs();
    Valid_C2M          = '0;
    Data_C2M           = '0;
    Addr_C2M           = '0;
    We_C2M             = '0;
    ReqReady_A2M       = 1'b0;
    CompleteValid_M2A  = 1'b0;
    AccessComplete_M2C = '0;
    Data_M2C           = '0;
  endtask

  task automatic do_reset();
    zero_inputs();
    rst_l = 1'b0;
    tick();
    tick();
    rst_l = 1'b1;
    tick();
  endtask

  // Plays the memory for one transaction; ok=0 if no request shows up in time.
  task automatic serve(input logic [BW-1:0] rdata, output logic [AW-1:0] addr,
                       output logic [1:0] resp, output logic [BW-1:0] rd, output bit ok);
    ok   = 1'b0;
    addr = '0;
    resp = '0;
    rd   = '0;
    for (int n = 0; n < 20 && !ReqValid_A2M; n++) tick();
    if (ReqValid_A2M) begin
      addr         = Addr_A2M;
      ReqReady_A2M = 1'b1;
      tick();
      ReqReady_A2M       = 1'b0;
      CompleteValid_M2A  = 1'b1;
      AccessComplete_M2C = addr;
      Data_M2C           = rdata;
      tick();
      CompleteValid_M2A = 1'b0;
      resp = RespValid_A2C;
      rd   = RespData_A2C;
      ok   = 1'b1;
      tick();
    end
  endtask

  task automatic test_reset();
    zero_inputs();
    rst_l = 1'b0;
    #3;
    total++; if (ReqValid_A2M !== 1'b0) begin bad++; $display("FAIL rst_reqvalid got=%0h exp=0", ReqValid_A2M); end
    total++; if (RespValid_A2C !== 2'b00) begin bad++; $display("FAIL rst_respvalid got=%0h exp=0", RespValid_A2C); end
    total++; if (Addr_A2M !== '0 || Data_A2M !== '0 || We_A2M !== 1'b0) begin
      bad++; $display("FAIL rst_req_bus got=%0h/%0h/%0h exp=0/0/0", Addr_A2M, Data_A2M, We_A2M);
    end
    total++; if (RespData_A2C !== '0) begin bad++; $display("FAIL rst_respdata got=%0h exp=0", RespData_A2C); end
    total++; if (Timeout_err !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%0h exp=0", Timeout_err); end
    tick();
    tick();
    rst_l = 1'b1;
    tick();
    total++; if (Ready_C2M !== 2'b11) begin bad++; $display("FAIL rst_ready got=%0h exp=3", Ready_C2M); end
  endtask

  task automatic test_single();
    do_reset();
    Valid_C2M[0] = 1'b1;
    Addr_C2M[0]  = 32'h100;
    tick();
    Valid_C2M[0] = 1'b0;
    total++; if (ReqValid_A2M !== 1'b0) begin bad++; $display("FAIL single_push_cycle got=%0h exp=0", ReqValid_A2M); end
    tick();
    total++; if (ReqValid_A2M !== 1'b1 || Addr_A2M !== 32'h100 || We_A2M !== 1'b0) begin
      bad++; $display("FAIL single_issue got=%0h/%0h/%0h exp=1/100/0", ReqValid_A2M, Addr_A2M, We_A2M);
    end
    ReqReady_A2M = 1'b1;
    tick();
    ReqReady_A2M = 1'b0;
    total++; if (ReqValid_A2M !== 1'b0 || RespValid_A2C !== 2'b00) begin
      bad++; $display("FAIL single_wait got=%0h/%0h exp=0/0", ReqValid_A2M, RespValid_A2C);
    end
    CompleteValid_M2A  = 1'b1;
    AccessComplete_M2C = 32'h100;
    Data_M2C           = 32'hAB;
    tick();
    CompleteValid_M2A = 1'b0;
    total++; if (RespValid_A2C !== 2'b01 || RespData_A2C !== 32'hAB) begin
      bad++; $display("FAIL single_resp got=%0h/%0h exp=1/ab", RespValid_A2C, RespData_A2C);
    end
    tick();
    total++; if (RespValid_A2C !== 2'b00 || RespData_A2C !== '0) begin
      bad++; $display("FAIL single_resp_pulse got=%0h/%0h exp=0/0", RespValid_A2C, RespData_A2C);
    end
    // Write from port 1: grant moves on from port 0.
    Valid_C2M[1] = 1'b1;
    Addr_C2M[1]  = 32'h104;
    Data_C2M[1]  = 32'hDEAD;
    We_C2M[1]    = 1'b1;
    tick();
    Valid_C2M[1] = 1'b0;
    tick();
    total++; if (ReqValid_A2M !== 1'b1 || Addr_A2M !== 32'h104 || Data_A2M !== 32'hDEAD || We_A2M !== 1'b1) begin
      bad++; $display("FAIL write_issue got=%0h/%0h/%0h/%0h exp=1/104/dead/1", ReqValid_A2M, Addr_A2M, Data_A2M, We_A2M);
    end
    ReqReady_A2M = 1'b1;
    tick();
    ReqReady_A2M       = 1'b0;
    CompleteValid_M2A  = 1'b1;
    AccessComplete_M2C = 32'h104;
    Data_M2C           = 32'h77;
    tick();
    CompleteValid_M2A = 1'b0;
    total++; if (RespValid_A2C !== 2'b10 || RespData_A2C !== 32'h77) begin
      bad++; $display("FAIL write_resp got=%0h/%0h exp=2/77", RespValid_A2C, RespData_A2C);
    end
    tick();
  endtask

  task automatic test_fairness();
    logic [AW-1:0] addr, exp_addr;
    logic [1:0]    resp, exp_resp;
    logic [BW-1:0] rd;
    bit            ok;
    do_reset();
    Valid_C2M = 2'b11;
    for (int k = 0; k < 3; k++) begin
      Addr_C2M[0] = 32'h10 + k;
      Addr_C2M[1] = 32'h20 + k;
      tick();
    end
    Valid_C2M = 2'b00;
    for (int k = 0; k < 6; k++) begin
      serve(32'h1000 + k, addr, resp, rd, ok);
      exp_addr = (k % 2 == 0) ? 32'h10 + k / 2 : 32'h20 + k / 2;
      exp_resp = (k % 2 == 0) ? 2'b01 : 2'b10;
      total++; if (!ok || addr !== exp_addr || resp !== exp_resp || rd !== 32'h1000 + k) begin
        bad++;
        $display("FAIL fair_%0d got ok=%0d addr=%0h resp=%0h data=%0h exp addr=%0h resp=%0h data=%0h",
                 k, ok, addr, resp, rd, exp_addr, exp_resp, 32'h1000 + k);
      end
    end
  endtask

  task automatic test_full_queue();
    logic [AW-1:0] addr;
    logic [1:0]    resp;
    logic [BW-1:0] rd;
    bit            ok;
    do_reset();
    Valid_C2M[1] = 1'b1;
    // First entry is popped into ISSUE, so the queue fills on the fifth push.
    for (int k = 0; k < 5; k++) begin
      Addr_C2M[1] = 32'h30 + k;
      tick();
      total++; if (Ready_C2M[1] !== (k < 4)) begin
        bad++; $display("FAIL full_ready_%0d got=%0h exp=%0h", k, Ready_C2M[1], (k < 4));
      end
    end
    Addr_C2M[1] = 32'h35;
    tick();
    tick();
    total++; if (Ready_C2M[1] !== 1'b0) begin bad++; $display("FAIL full_held got=%0h exp=0", Ready_C2M[1]); end
    serve(32'h0, addr, resp, rd, ok);
    total++; if (!ok || addr !== 32'h30 || resp !== 2'b10) begin
      bad++; $display("FAIL full_first got ok=%0d addr=%0h resp=%0h exp addr=30 resp=2", ok, addr, resp);
    end
    for (int n = 0; n < 10 && !Ready_C2M[1]; n++) tick();
    total++; if (Ready_C2M[1] !== 1'b1) begin bad++; $display("FAIL full_reopen got=%0h exp=1", Ready_C2M[1]); end
    tick();
    Valid_C2M[1] = 1'b0;
    for (int k = 1; k < 6; k++) begin
      serve(32'h0, addr, resp, rd, ok);
      total++; if (!ok || addr !== 32'h30 + k || resp !== 2'b10) begin
        bad++; $display("FAIL full_drain_%0d got ok=%0d addr=%0h resp=%0h exp addr=%0h resp=2", k, ok, addr, resp, 32'h30 + k);
      end
    end
    repeat (5) tick();
    total++; if (ReqValid_A2M !== 1'b0) begin bad++; $display("FAIL full_empty got=%0h exp=0", ReqValid_A2M); end
  endtask

  task automatic test_mismatch();
    logic [1:0] seen;
    do_reset();
    Valid_C2M[0] = 1'b1;
    Addr_C2M[0]  = 32'h100;
    tick();
    Valid_C2M[0] = 1'b0;
    for (int n = 0; n < 10 && !ReqValid_A2M; n++) tick();
    total++; if (ReqValid_A2M !== 1'b1) begin bad++; $display("FAIL mis_issue got=%0h exp=1", ReqValid_A2M); end
    ReqReady_A2M = 1'b1;
    tick();
    ReqReady_A2M       = 1'b0;
    CompleteValid_M2A  = 1'b1;
    AccessComplete_M2C = 32'h200;
    Data_M2C           = 32'h11;
    tick();
    CompleteValid_M2A = 1'b0;
    seen = RespValid_A2C;
    repeat (3) begin tick(); seen |= RespValid_A2C; end
`ifndef NOC_ARB_TIMEOUT_EN
    // Without the timeout, WAIT must hold well past TIMEOUT_CYCLES.
    repeat (12) begin tick(); seen |= RespValid_A2C; end
    total++; if (Timeout_err !== 1'b0 || ReqValid_A2M !== 1'b0) begin
      bad++; $display("FAIL mis_hold got=%0h/%0h exp=0/0", Timeout_err, ReqValid_A2M);
    end
`endif
    total++; if (seen !== 2'b00) begin bad++; $display("FAIL mis_ignored got=%0h exp=0", seen); end
    CompleteValid_M2A  = 1'b1;
    AccessComplete_M2C = 32'h100;
    Data_M2C           = 32'h22;
    tick();
    CompleteValid_M2A = 1'b0;
    total++; if (RespValid_A2C !== 2'b01 || RespData_A2C !== 32'h22) begin
      bad++; $display("FAIL mis_match got=%0h/%0h exp=1/22", RespValid_A2C, RespData_A2C);
    end
    tick();
  endtask

`ifdef NOC_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    do_reset();
    Valid_C2M[0] = 1'b1;
    Addr_C2M[0]  = 32'h100;
    tick();
    Valid_C2M[0] = 1'b0;
    for (int k = 0; k < 10 && !ReqValid_A2M; k++) tick();
    ReqReady_A2M = 1'b1;
    tick();
    ReqReady_A2M = 1'b0;
    n = 0;
    while (n < 40 && RespValid_A2C == 2'b00) begin tick(); n++; end
    total++; if (n != 8) begin bad++; $display("FAIL to_cycles got=%0d exp=8", n); end
    total++; if (RespValid_A2C !== 2'b01 || RespData_A2C !== '0 || Timeout_err !== 1'b1) begin
      bad++; $display("FAIL to_resp got=%0h/%0h/%0h exp=1/0/1", RespValid_A2C, RespData_A2C, Timeout_err);
    end
    tick();
    total++; if (RespValid_A2C !== 2'b00 || ReqValid_A2M !== 1'b0 || Timeout_err !== 1'b1) begin
      bad++; $display("FAIL to_idle got=%0h/%0h/%0h exp=0/0/1", RespValid_A2C, ReqValid_A2M, Timeout_err);
    end
  endtask
`endif

  task automatic test_reset_in_wait();
    logic seen;
    do_reset();
    Valid_C2M   = 2'b11;
    Addr_C2M[0] = 32'h40;
    Addr_C2M[1] = 32'h50;
    tick();
    Valid_C2M   = 2'b01;
    Addr_C2M[0] = 32'h41;
    tick();
    Valid_C2M = 2'b00;
    total++; if (ReqValid_A2M !== 1'b1 || Addr_A2M !== 32'h40) begin
      bad++; $display("FAIL rw_issue got=%0h/%0h exp=1/40", ReqValid_A2M, Addr_A2M);
    end
    ReqReady_A2M = 1'b1;
    tick();
    ReqReady_A2M = 1'b0;
    #2;
    rst_l = 1'b0;
    #1;
    total++; if (ReqValid_A2M !== 1'b0 || RespValid_A2C !== 2'b00 || Addr_A2M !== '0 ||
                 Data_A2M !== '0 || We_A2M !== 1'b0 || RespData_A2C !== '0 || Timeout_err !== 1'b0) begin
      bad++; $display("FAIL rw_async got=%0h/%0h/%0h/%0h/%0h/%0h/%0h exp=all 0", ReqValid_A2M,
                      RespValid_A2C, Addr_A2M, Data_A2M, We_A2M, RespData_A2C, Timeout_err);
    end
    #3;
    rst_l = 1'b1;
    CompleteValid_M2A  = 1'b1;
    AccessComplete_M2C = 32'h40;
    tick();
    CompleteValid_M2A = 1'b0;
    seen = ReqValid_A2M | (|RespValid_A2C);
    repeat (10) begin tick(); seen |= ReqValid_A2M | (|RespValid_A2C); end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rw_flushed got=%0h exp=0", seen); end
    total++; if (Ready_C2M !== 2'b11) begin bad++; $display("FAIL rw_ready got=%0h exp=3", Ready_C2M); end
  endtask

  initial begin
    rst_l = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_full_queue();
    test_mismatch();
`ifdef NOC_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
